// File: rtl/frame_sequencer.sv
// frame_sequencer: copies the committed next-target frame into the target buffer at a frame boundary
// and tracks elapsed frames of the committed animation. Optional SEQ_STATS_EN adds commit/overrun counters.
module frame_sequencer #(
   parameter int c_ledboards = 30,
   parameter int c_bpc = 12,
   parameter int c_max_time = 1024,
   parameter int c_max_type = 64,
   localparam int c_time_w = $clog2(c_max_time),
   localparam int c_type_w = $clog2(c_max_type),
   localparam int c_addr_w = $clog2(c_ledboards * 32)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_commit,
   input  logic                i_frame,
   output logic [c_addr_w-1:0] o_raddr,
   input  logic [c_bpc-1:0]    i_rdata,
   input  logic [c_time_w-1:0] i_time,
   input  logic [c_type_w-1:0] i_type,
   output logic                o_wen,
   output logic [c_addr_w-1:0] o_waddr,
   output logic [c_bpc-1:0]    o_wdata,
   output logic [c_time_w-1:0] o_time,
   output logic [c_type_w-1:0] o_type,
   output logic [c_time_w-1:0] o_elapsed,
   output logic                o_done,
   output logic                o_busy,
`ifdef SEQ_STATS_EN
   output logic                o_overrun,
   output logic [15:0]         o_commits,
   output logic [15:0]         o_overruns
`else
   output logic                o_overrun
`endif
);
   typedef enum logic [1:0] {IDLE, ARMED, COPY, FLUSH} state_t;
   localparam logic [c_addr_w-1:0] last = c_addr_w'(c_ledboards * 32 - 1);
   state_t state;
   logic pending;
   // read data arrives one cycle after the address, so it lines up with the delayed write address
   assign o_wdata = o_wen ? i_rdata : '0;
   assign o_done = o_elapsed >= o_time;
   assign o_busy = state != IDLE;
   // sequencer: arm on commit, copy on frame boundary, publish header when the copy completes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         pending <= 1'b0;
         o_raddr <= '0;
         o_wen <= 1'b0;
         o_waddr <= '0;
         o_overrun <= 1'b0;
         o_time <= '0;
         o_type <= '0;
         o_elapsed <= '0;
      end else begin
         o_wen <= state == COPY;
         o_waddr <= state == COPY ? o_raddr : '0;
         o_raddr <= (state == COPY && o_raddr != last) ? o_raddr + c_addr_w'(1) : '0;
         o_overrun <= 1'b0;
         o_elapsed <= state == FLUSH ? '0 :
                      (i_frame && o_elapsed < o_time) ? o_elapsed + c_time_w'(1) : o_elapsed;
         case (state)
            IDLE: if (i_commit) state <= i_frame ? COPY : ARMED;
            ARMED: begin
               o_overrun <= i_commit;
               if (i_frame) state <= COPY;
            end
            COPY: begin
               if (i_commit) begin
                  o_overrun <= pending;
                  pending <= 1'b1;
               end
               if (o_raddr == last) state <= FLUSH;
            end
            default: begin
               o_time <= i_time;
               o_type <= i_type;
               o_overrun <= pending & i_commit;
               state <= (pending | i_commit) ? ARMED : IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end
`ifdef SEQ_STATS_EN
   // completed copies and overrun pulses, both wrapping
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_commits <= '0;
         o_overruns <= '0;
      end else begin
         o_commits <= o_commits + 16'(state == FLUSH);
         o_overruns <= o_overruns + 16'(o_overrun);
      end
   end
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed stimulus with a write scoreboard for frame_sequencer (C=32)
module tb_frame_sequencer;
   logic clk = 0, rst = 1, commit = 0, frame = 0;
   logic [4:0] raddr, waddr;
   logic [11:0] rdata, wdata;
   logic [9:0] tim = 0, otime, elapsed;
   logic [5:0] typ = 0, otype;
   logic wen, done, busy, overrun;
`ifdef SEQ_STATS_EN
   logic [15:0] commits, overruns;
`endif
   int checks = 0, errors = 0, cyc = 0;
   int wr_cnt = 0, wr_first = 0, wr_last = 0, copy_cyc = 0, n;
   logic [16:0] exp_q[$];
   logic [16:0] e_item;
   int exp_el[5] = '{1, 2, 3, 3, 3};
   int exp_dn[5] = '{0, 0, 1, 1, 1};

   frame_sequencer #(.c_ledboards(1), .c_bpc(12), .c_max_time(1024), .c_max_type(64)) dut (
      .i_clk(clk), .i_rst(rst), .i_commit(commit), .i_frame(frame),
      .o_raddr(raddr), .i_rdata(rdata), .i_time(tim), .i_type(typ),
      .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_time(otime), .o_type(otype),
      .o_elapsed(elapsed), .o_done(done), .o_busy(busy),
`ifdef SEQ_STATS_EN
      .o_overrun(overrun), .o_commits(commits), .o_overruns(overruns)
`else
      .o_overrun(overrun)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // source buffer: word[n] = n + 0x100, one cycle read latency
   always @(posedge clk) rdata <= 12'h100 + 12'(raddr);

   // monitor: every target write is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (wen) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h expected none", waddr, wdata);
         end else begin
            e_item = exp_q.pop_front();
            if ({waddr, wdata} !== e_item) begin
               errors++;
               $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                        waddr, wdata, e_item[16:12], e_item[11:0]);
            end
         end
         if (wr_cnt == 0) wr_first = cyc;
         wr_last = cyc;
         wr_cnt++;
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_copy;
      for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 12'(12'h100 + i)});
      wr_cnt = 0;
   endtask

   task automatic wait_idle(int lim);
      int k = 0;
      while (busy && k < lim) begin
         tick;
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      repeat (2) tick;
      rst = 0;
      repeat (10) tick;
      chk("rst_wen", int'(wen), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 1);
      chk("rst_time", int'(otime), 0);
      chk("rst_elapsed", int'(elapsed), 0);
      chk("rst_raddr", int'(raddr), 0);
`ifdef SEQ_STATS_EN
      chk("rst_commits", int'(commits), 0);
`endif
      // commit, then frame boundary 5 cycles later
      tim = 5; typ = 3;
      push_copy;
      commit = 1; tick; commit = 0;
      chk("armed_busy", int'(busy), 1);
      repeat (4) tick;
      chk("armed_no_write", int'(wen), 0);
      frame = 1; tick; frame = 0;
      copy_cyc = cyc;
      wait_idle(100);
      chk("copy_wen_count", wr_cnt, 32);
      chk("copy_consecutive", wr_last - wr_first + 1, 32);
      chk("copy_latency", wr_last - copy_cyc + 1, 33);
      chk("hdr_time", int'(otime), 5);
      chk("hdr_type", int'(otype), 3);
      chk("hdr_elapsed", int'(elapsed), 0);
      chk("hdr_done", int'(done), 0);
      chk("copy1_queue", exp_q.size(), 0);
      // same-cycle commit and frame in IDLE: COPY directly
      tim = 3; typ = 7;
      push_copy;
      commit = 1; frame = 1; tick; commit = 0; frame = 0;
      chk("direct_busy", int'(busy), 1);
      chk("direct_raddr0", int'(raddr), 0);
      tick;
      chk("direct_raddr1", int'(raddr), 1);
      wait_idle(100);
      chk("direct_time", int'(otime), 3);
      chk("direct_type", int'(otype), 7);
      chk("direct_queue", exp_q.size(), 0);
      // elapsed saturates at time=3
      for (int i = 0; i < 5; i++) begin
         frame = 1; tick; frame = 0;
         chk($sformatf("elapsed_%0d", i), int'(elapsed), exp_el[i]);
         chk($sformatf("done_%0d", i), int'(done), exp_dn[i]);
         tick;
      end
      // two commits while ARMED: one overrun, one copy
      push_copy;
      commit = 1; tick; commit = 0;
      chk("ovr_first", int'(overrun), 0);
      tick;
      commit = 1; tick; commit = 0;
      chk("ovr_pulse", int'(overrun), 1);
      tick;
      chk("ovr_one_cycle", int'(overrun), 0);
      frame = 1; tick; frame = 0;
      wait_idle(100);
      repeat (40) tick;
      chk("ovr_single_copy_idle", int'(busy), 0);
      chk("ovr_queue", exp_q.size(), 0);
      // commit during COPY sets pending, second one overruns
      push_copy;
      commit = 1; frame = 1; tick; commit = 0; frame = 0;
      repeat (5) tick;
      push_copy;
      commit = 1; tick; commit = 0;
      chk("pend_no_ovr", int'(overrun), 0);
      tick;
      commit = 1; tick; commit = 0;
      chk("pend_ovr", int'(overrun), 1);
      repeat (40) tick;
      chk("pend_armed_busy", int'(busy), 1);
      chk("pend_armed_wen", int'(wen), 0);
      chk("pend_queue_left", exp_q.size(), 32);
      frame = 1; tick; frame = 0;
      wait_idle(100);
      chk("pend_queue", exp_q.size(), 0);
      // async reset in the middle of a copy
      tim = 9; typ = 1;
      push_copy;
      commit = 1; frame = 1; tick; commit = 0; frame = 0;
      n = 0;
      while (raddr != 10 && n < 50) begin
         tick;
         n++;
      end
      chk("mid_raddr", int'(raddr), 10);
      rst = 1;
      #1;
      chk("mid_rst_wen", int'(wen), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_raddr", int'(raddr), 0);
      chk("mid_rst_time", int'(otime), 0);
      chk("mid_rst_type", int'(otype), 0);
      chk("mid_rst_done", int'(done), 1);
      chk("mid_rst_writes_left", exp_q.size(), 23);
`ifdef SEQ_STATS_EN
      chk("mid_rst_commits", int'(commits), 0);
`endif
      exp_q.delete();
      repeat (2) tick;
      rst = 0;
      repeat (5) tick;
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_wen", int'(wen), 0);
      chk("post_rst_time", int'(otime), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
